xillybus_loopback_fifo: RTL
===========================

// Module: xillybus_loopback_fifo
// PURPOSE
// - User-side endpoint for one Xillybus write/read stream pair of xillybus_core.
// - Acts as the FIFO sink for user_w_write*_32 (core writes in) and the FIFO
//   source for user_r_read*_32 (core reads out), giving a host loopback channel.
// - Generates end-of-file to the read side once the host closes the write stream
//   and the buffer has drained. One instance per channel pair.
// PARAMETERS
// - DEPTH   512  FIFO entries of 32 bits; power of two, >= 4
// - ADDR_W  9    log2(DEPTH)
// PORTS
// - bus_clk_w                input   1   bus clock, all logic rising-edge
// - bus_rst_n_w              input   1   async active-low reset
// - user_w_write_32_wren_w   input   1   core write strobe
// - user_w_write_32_data_w   input   32  core write data
// - user_w_write_32_open_w   input   1   host has write file open
// - user_w_write_32_full_w   output  1   FIFO full (registered)
// - user_r_read_32_rden_w    input   1   core read strobe
// - user_r_read_32_open_w    input   1   host has read file open
// - user_r_read_32_data_w    output  32  read data, valid cycle after rden
// - user_r_read_32_empty_w   output  1   FIFO empty (registered)
// - user_r_read_32_eof_w     output  1   end-of-file to read side
// - GPIO_LED_w               output  4   {eof, full, empty, write_open}
// - dropped_count_w          output  16  overflow drops (see CONFIGURATION)
// BEHAVIOUR
// - Reset: pointers and count = 0, empty=1, full=0, eof=0, data=0, eof_pending=0,
//   dropped_count=0, LED=4'b0010 (empty lit).
// - Standard (non-FWFT) FIFO: rden && !empty at edge N -> data valid from N+1
//   and held until the next accepted read. rden while empty is ignored.
// - Write is accepted iff wren && !full, using full as registered before the edge.
//   wren while full drops the word; no pointer change.
// - Simultaneous accepted read+write: count unchanged; both pointers advance.
// - Pointers are ADDR_W bits and wrap DEPTH-1 -> 0. Count is ADDR_W+1 bits.
// - empty/full are registered from next-count (count==0 / count==DEPTH) and
//   are valid in the same cycle the count changes.
// - EOF state machine, states IDLE, OPEN, DRAIN:
//   - IDLE -> OPEN when write_open rises.
//   - OPEN -> DRAIN when write_open falls; eof_pending=1.
//   - In DRAIN, eof = empty && read_open (registered; asserts with empty).
//   - DRAIN -> IDLE when read_open falls; eof clears.
//   - write_open re-rising in DRAIN -> OPEN and eof clears.
// - Falling read_open flushes the FIFO: pointers/count -> 0, empty=1, and any
//   eof_pending is cleared. A write in the same cycle is discarded.
// - Reset mid-transfer: immediate async return to reset values; contents lost.
// CONFIGURATION
// - XFIFO_DROP_COUNT_EN defined: dropped_count_w increments on each wren while
//   full and saturates at 16'hFFFF; it is cleared on a rising edge of write_open.
// - Not defined: dropped_count_w tied to 16'h0 and no counter logic is built.
// TESTING
// - Reset, then write 3 words A,B,C with no reads -> empty falls 1 cycle after
//   the first wren; three rden -> A,B,C one cycle each; empty=1 after the third.
// - Fill 512 words -> full=1 after the 512th; a 513th wren (0xDEAD) is dropped,
//   readback yields words 1..512 only; with macro set, dropped_count_w=1.
// - Steady simultaneous rden+wren at count=5 for 1000 cycles -> count stays 5,
//   pointers wrap, data order preserved.
// - Open write, write 2 words, close write -> eof stays 0 until the 2nd read
//   drains the FIFO, then eof=1 together with empty=1.
// - Close read_open with 10 words queued -> next cycle empty=1, eof=0; reopen
//   and read -> stays empty.
// - Assert bus_rst_n_w low mid-burst at count=7 -> all outputs return to reset
//   values asynchronously, LED=4'b0010.

Source files
------------

// File: rtl/xillybus_loopback_fifo.sv
// Loopback FIFO endpoint for one Xillybus write/read stream pair, with end-of-file generation.
// Optional overflow drop counter is built when XFIFO_DROP_COUNT_EN is defined.
module xillybus_loopback_fifo #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic        bus_clk_w,
  input  logic        bus_rst_n_w,
  input  logic        user_w_write_32_wren_w,
  input  logic [31:0] user_w_write_32_data_w,
  input  logic        user_w_write_32_open_w,
  output logic        user_w_write_32_full_w,
  input  logic        user_r_read_32_rden_w,
  input  logic        user_r_read_32_open_w,
  output logic [31:0] user_r_read_32_data_w,
  output logic        user_r_read_32_empty_w,
  output logic        user_r_read_32_eof_w,
  output logic [3:0]  GPIO_LED_w,
  output logic [15:0] dropped_count_w
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    DRAIN = 2'd2
  } eof_state_e;

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic [31:0]       data_q;
  logic              wopen_q, ropen_q;
  eof_state_e        state_q, state_d;
  logic              eof_pending_q, eof_pending_d;
  logic              eof_q, eof_d;

  logic wr_accept, rd_accept, flush, wopen_rise, wopen_fall;

  assign wr_accept  = user_w_write_32_wren_w && !full_q;
  assign rd_accept  = user_r_read_32_rden_w && !empty_q;
  assign flush      = ropen_q && !user_r_read_32_open_w;
  assign wopen_rise = user_w_write_32_open_w && !wopen_q;
  assign wopen_fall = !user_w_write_32_open_w && wopen_q;

  // A closing read file discards everything, including a write in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + COUNT_ONE;
        2'b01:   count_d = count_q - COUNT_ONE;
        default: count_d = count_q;
      endcase
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_COUNT);
  end

  always_ff @(posedge bus_clk_w) begin
    if (wr_accept && !flush) begin
      mem_q[wr_ptr_q] <= user_w_write_32_data_w;
    end
  end

  always_ff @(posedge bus_clk_w or negedge bus_rst_n_w) begin
    if (!bus_rst_n_w) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      data_q   <= '0;
      wopen_q  <= 1'b0;
      ropen_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      wopen_q  <= user_w_write_32_open_w;
      ropen_q  <= user_r_read_32_open_w;
      if (rd_accept) data_q <= mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge bus_clk_w or negedge bus_rst_n_w) begin
    if (!bus_rst_n_w) begin
      state_q       <= IDLE;
      eof_pending_q <= 1'b0;
      eof_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      eof_pending_q <= eof_pending_d;
      eof_q         <= eof_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wopen_rise) state_d = OPEN;
      OPEN:    if (wopen_fall) state_d = DRAIN;
      DRAIN: begin
        if (wopen_rise)  state_d = OPEN;
        else if (flush)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // eof is computed from next-state values so it rises on the same edge as empty.
  always_comb begin
    eof_pending_d = eof_pending_q;
    if (flush)                                    eof_pending_d = 1'b0;
    else if (state_q == OPEN && state_d == DRAIN) eof_pending_d = 1'b1;
    else if (state_d != DRAIN)                    eof_pending_d = 1'b0;
    eof_d = (state_d == DRAIN) && eof_pending_d && empty_d && user_r_read_32_open_w;
  end

`ifdef XFIFO_DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (wopen_rise) begin
      drop_cnt_d = '0;
    end else if (user_w_write_32_wren_w && full_q && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge bus_clk_w or negedge bus_rst_n_w) begin
    if (!bus_rst_n_w) drop_cnt_q <= '0;
    else              drop_cnt_q <= drop_cnt_d;
  end

  assign dropped_count_w = drop_cnt_q;
`else
  assign dropped_count_w = 16'h0;
`endif

  assign user_w_write_32_full_w = full_q;
  assign user_r_read_32_data_w  = data_q;
  assign user_r_read_32_empty_w = empty_q;
  assign user_r_read_32_eof_w   = eof_q;
  assign GPIO_LED_w             = {eof_q, full_q, empty_q, wopen_q};

endmodule
